exec_mem_unit: RTL and testbench
================================

EXEC_MEM_UNIT -- requirements
Module: exec_mem_unit

Interface
REQ-001 The block SHALL have parameter PC_W, default 9, giving the PC adder width.
REQ-002 The block SHALL have parameter DATA_W, default 64, giving the ALU and memory data width.
REQ-003 The block SHALL have parameter DM_ADDRESS, default 9, giving the memory word-address width (2**DM_ADDRESS words).
REQ-004 The block SHALL have parameter ALU_CC_W, default 4, giving the ALU control-code width.
REQ-005 The block SHALL use one clock and a synchronous, active-high reset.
REQ-006 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-007 The block SHALL have port reset, input, 1 bit, the synchronous active-high reset.
REQ-008 The block SHALL have port pc_a, input, PC_W bits, adder operand A (current PC).
REQ-009 The block SHALL have port pc_b, input, PC_W bits, adder operand B (increment, normally 4).
REQ-010 The block SHALL have port pc_sum, output, PC_W bits, adder result.
REQ-011 The block SHALL have port SrcA, input, DATA_W bits, ALU operand A.
REQ-012 The block SHALL have port SrcB, input, DATA_W bits, ALU operand B.
REQ-013 The block SHALL have port ALUCC, input, ALU_CC_W bits, ALU operation select.
REQ-014 The block SHALL have port ALUResult, output, DATA_W bits, ALU result; also the memory address source.
REQ-015 The block SHALL have port MemRead, input, 1 bit, enables the memory read.
REQ-016 The block SHALL have port MemWrite, input, 1 bit, enables the memory write.
REQ-017 The block SHALL have port WriteData, input, DATA_W bits, the memory store data.
REQ-018 The block SHALL have port ReadData, output, DATA_W bits, the memory load data.

Function
REQ-019 pc_sum SHALL equal (pc_a + pc_b) mod 2**PC_W, combinational, carry discarded (0x1FC+4 -> 0x000).
REQ-020 ALUResult SHALL be combinational from SrcA, SrcB and ALUCC, zero latency.
REQ-021 ALUCC 0000 SHALL select AND, 0001 OR, 0010 ADD, 0011 XOR, 0110 SUB (A-B).
REQ-022 ALUCC 0111 SHALL select signed SLT; 1001 SHALL select unsigned SLTU; both give a result of 1 or 0, zero-extended.
REQ-023 ALUCC 0100 SHALL select SLL, 0101 SRL and 1000 SRA, with shift amount SrcB[5:0].
REQ-024 ALUCC 1100 SHALL select NOR; every other code SHALL give 0.
REQ-025 ADD and SUB SHALL wrap modulo 2**DATA_W, and overflow SHALL not be flagged.
REQ-026 Memory SHALL be 2**DM_ADDRESS words of DATA_W bits, word-addressed by ALUResult[DM_ADDRESS-1:0]; upper ALUResult bits SHALL be ignored, so the address wraps.
REQ-027 ReadData SHALL be mem[addr] combinationally when MemRead=1, else 0.
REQ-028 When MemWrite=1 and reset=0 at a rising clk edge, mem[addr] SHALL take the value of WriteData.
REQ-029 When MemRead and MemWrite are both 1 on the same address, ReadData SHALL show the old word before the edge and the new word after it.
REQ-030 When MemWrite=0, memory contents SHALL be unchanged.

Reset
REQ-031 On a rising edge with reset=1, all memory words SHALL clear to 0, and any concurrent write SHALL be suppressed.
REQ-032 Immediately after reset, ReadData SHALL be 0 for any address; pc_sum and ALUResult are combinational and SHALL be unaffected by reset.
REQ-033 A reset asserted between a write and a later read SHALL cause the read to return 0.

Structure
REQ-034 A shared package SHALL hold the ALUCC encoding constants and the default width parameters.
REQ-035 The memory array SHALL be one sub-module named exec_dmem, containing the clock, reset, write and read logic.
REQ-036 The adder and the ALU SHALL be combinational logic in the top module.

Verification
REQ-037 Adder: pc_a=0x000, pc_b=4 -> pc_sum=0x004; pc_a=0x1FC, pc_b=4 -> pc_sum=0x000.
REQ-038 ALU: SrcA=5, SrcB=7, ALUCC=0110 -> 0xFFFF_FFFF_FFFF_FFFE; with ALUCC=0111 -> 1; with SrcA=-1, SrcB=1 and ALUCC=1001 -> 0.
REQ-039 Shifts: SrcA=0x8000_0000_0000_0000, SrcB=0x41, ALUCC=1000 -> 0xC000_0000_0000_0000; with ALUCC=0101 -> 0x4000_0000_0000_0000.
REQ-040 Store/load: ALUResult=0x208 (address 8), MemWrite=1, WriteData=0xDEADBEEF, one edge; then MemRead=1 -> ReadData=0xDEADBEEF; with MemRead=0 -> ReadData=0.
REQ-041 Reset: write 0x1234 to address 3, assert reset for one edge, read address 3 -> 0; write attempted during reset -> 0.
REQ-042 Undefined code: ALUCC=1111 with any operands -> ALUResult=0.

Source files
------------

// File: rtl/exec_mem_unit_pkg.sv
// Shared widths and ALU operation encodings for the execute/memory slice.
package exec_mem_unit_pkg;

    localparam int PC_W_DEF       = 9;
    localparam int DATA_W_DEF     = 64;
    localparam int DM_ADDRESS_DEF = 9;
    localparam int ALU_CC_W_DEF   = 4;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_SLL  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SRA  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;
    localparam logic [3:0] ALU_NOR  = 4'b1100;

endpackage

// File: rtl/exec_mem_unit_if.sv
// Word-addressed data-memory bus between the execute stage and the memory array.
interface exec_mem_unit_if
    import exec_mem_unit_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int DM_ADDRESS = DM_ADDRESS_DEF
);
    logic [DM_ADDRESS-1:0] addr;
    logic                  rd_en;
    logic                  wr_en;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W-1:0]     rdata;

    modport master (output addr, rd_en, wr_en, wdata, input rdata);
    modport slave  (input addr, rd_en, wr_en, wdata, output rdata);
endinterface

// File: rtl/exec_dmem.sv
// Data memory: synchronous write and clear, combinational gated read.
module exec_dmem
    import exec_mem_unit_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int DM_ADDRESS = DM_ADDRESS_DEF
) (
    input  logic             clk,
    input  logic             reset,
    exec_mem_unit_if.slave   bus
);
    localparam int DEPTH = 2 ** DM_ADDRESS;

    logic [DATA_W-1:0] mem [DEPTH];

    // Reset wipes the whole array and takes priority over a concurrent store.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (bus.wr_en) begin
            mem[bus.addr] <= bus.wdata;
        end
    end

    assign bus.rdata = bus.rd_en ? mem[bus.addr] : '0;

endmodule

// File: rtl/exec_mem_unit.sv
// Execute/memory slice: PC adder, ALU and the data memory addressed by the ALU result.
module exec_mem_unit
    import exec_mem_unit_pkg::*;
#(
    parameter int PC_W       = PC_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int DM_ADDRESS = DM_ADDRESS_DEF,
    parameter int ALU_CC_W   = ALU_CC_W_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [PC_W-1:0]     pc_a,
    input  logic [PC_W-1:0]     pc_b,
    output logic [PC_W-1:0]     pc_sum,
    input  logic [DATA_W-1:0]   SrcA,
    input  logic [DATA_W-1:0]   SrcB,
    input  logic [ALU_CC_W-1:0] ALUCC,
    output logic [DATA_W-1:0]   ALUResult,
    input  logic                MemRead,
    input  logic                MemWrite,
    input  logic [DATA_W-1:0]   WriteData,
    output logic [DATA_W-1:0]   ReadData
);
    logic [5:0] shamt;

    assign pc_sum = pc_a + pc_b;
    assign shamt  = SrcB[5:0];

    always_comb begin
        ALUResult = '0;
        case (ALUCC)
            ALU_CC_W'(ALU_AND):  ALUResult = SrcA & SrcB;
            ALU_CC_W'(ALU_OR):   ALUResult = SrcA | SrcB;
            ALU_CC_W'(ALU_ADD):  ALUResult = SrcA + SrcB;
            ALU_CC_W'(ALU_XOR):  ALUResult = SrcA ^ SrcB;
            ALU_CC_W'(ALU_SUB):  ALUResult = SrcA - SrcB;
            ALU_CC_W'(ALU_SLT):  ALUResult = {{(DATA_W-1){1'b0}}, $signed(SrcA) < $signed(SrcB)};
            ALU_CC_W'(ALU_SLTU): ALUResult = {{(DATA_W-1){1'b0}}, SrcA < SrcB};
            ALU_CC_W'(ALU_SLL):  ALUResult = SrcA << shamt;
            ALU_CC_W'(ALU_SRL):  ALUResult = SrcA >> shamt;
            ALU_CC_W'(ALU_SRA):  ALUResult = DATA_W'($signed(SrcA) >>> shamt);
            ALU_CC_W'(ALU_NOR):  ALUResult = ~(SrcA | SrcB);
            default:             ALUResult = '0;
        endcase
    end

    // Only the low address bits reach the array, so large results wrap.
    exec_mem_unit_if #(.DATA_W(DATA_W), .DM_ADDRESS(DM_ADDRESS)) mbus ();

    assign mbus.addr  = ALUResult[DM_ADDRESS-1:0];
    assign mbus.rd_en = MemRead;
    assign mbus.wr_en = MemWrite;
    assign mbus.wdata = WriteData;
    assign ReadData   = mbus.rdata;

    exec_dmem #(.DATA_W(DATA_W), .DM_ADDRESS(DM_ADDRESS)) u_dmem (
        .clk   (clk),
        .reset (reset),
        .bus   (mbus.slave)
    );

endmodule

// File: tb/tb_exec_mem_unit.sv
// Directed plus randomized bench for exec_mem_unit with an arithmetic reference model.
module tb_exec_mem_unit;
    import exec_mem_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [8:0]  pc_a, pc_b, pc_sum;
    logic [63:0] SrcA, SrcB, ALUResult, WriteData;
    logic [3:0]  ALUCC;

    int checks   = 0;
    int failures = 0;

    logic [63:0] mm [512];

    exec_mem_unit_if #(.DATA_W(64), .DM_ADDRESS(9)) mb ();

    exec_mem_unit dut (
        .clk       (clk),
        .reset     (reset),
        .pc_a      (pc_a),
        .pc_b      (pc_b),
        .pc_sum    (pc_sum),
        .SrcA      (SrcA),
        .SrcB      (SrcB),
        .ALUCC     (ALUCC),
        .ALUResult (ALUResult),
        .MemRead   (mb.rd_en),
        .MemWrite  (mb.wr_en),
        .WriteData (WriteData),
        .ReadData  (mb.rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref_alu(input logic [63:0] a, input logic [63:0] b,
                                            input logic [3:0] cc);
        int sh;
        logic [63:0] r;
        sh = int'(b[5:0]);
        case (cc)
            4'd0:  return a & b;
            4'd1:  return a | b;
            4'd2:  return a + b;
            4'd3:  return a ^ b;
            4'd6:  return a + (~b + 64'd1);
            4'd7:  begin
                if (a[63] != b[63]) return {63'd0, a[63]};
                return {63'd0, a < b};
            end
            4'd9:  return {63'd0, a < b};
            4'd4:  return a * (64'd1 << sh);
            4'd5:  return a / (64'd1 << sh);
            4'd8:  begin
                r = a;
                for (int k = 0; k < sh; k++) r = {r[63], r[63:1]};
                return r;
            end
            4'd12: return ~(a | b);
            default: return 64'd0;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        if (reset) begin
            for (int k = 0; k < 512; k++) mm[k] = 64'd0;
        end else if (mb.wr_en) begin
            mm[mb.addr] = WriteData;
        end
        @(negedge clk);
    endtask

    // Steer the ALU to produce a chosen address, with random junk above the address bits.
    task automatic set_addr(input logic [8:0] a);
        logic [63:0] t;
        t = {$urandom, $urandom};
        t[8:0] = a;
        mb.addr = a;
        SrcA = t;
        SrcB = 64'd0;
        ALUCC = ALU_ADD;
    endtask

    initial begin
        logic [8:0] a;
        logic [3:0] cc;
        logic rst;
        reset = 1'b1; pc_a = '0; pc_b = '0; SrcA = '0; SrcB = '0; ALUCC = '0;
        mb.addr = '0; mb.rd_en = 1'b0; mb.wr_en = 1'b0; WriteData = '0;
        for (int k = 0; k < 512; k++) mm[k] = 64'hx;
        @(negedge clk);
        tick();
        // Combinational paths remain live while reset is held.
        pc_a = 9'h1FC; pc_b = 9'd4; SrcA = 64'd5; SrcB = 64'd7; ALUCC = 4'b0110;
        #1;
        chk("pc_in_reset", {55'd0, pc_sum}, 64'd0);
        chk("alu_in_reset", ALUResult, 64'hFFFF_FFFF_FFFF_FFFE);
        tick();
        reset = 1'b0;
        set_addr(9'd0); mb.rd_en = 1'b1;
        #1 chk("rst_rd0", mb.rdata, 64'd0);
        set_addr(9'd511);
        #1 chk("rst_rd511", mb.rdata, 64'd0);
        mb.rd_en = 1'b0;

        pc_a = 9'h000; pc_b = 9'd4;
        #1 chk("pc_0_4", {55'd0, pc_sum}, 64'h004);
        pc_a = 9'h1FC;
        #1 chk("pc_wrap", {55'd0, pc_sum}, 64'h000);

        SrcA = 64'd5; SrcB = 64'd7; ALUCC = 4'b0110;
        #1 chk("sub_neg", ALUResult, 64'hFFFF_FFFF_FFFF_FFFE);
        ALUCC = 4'b0111;
        #1 chk("slt", ALUResult, 64'd1);
        SrcA = '1; SrcB = 64'd1; ALUCC = 4'b1001;
        #1 chk("sltu", ALUResult, 64'd0);
        SrcA = 64'h8000_0000_0000_0000; SrcB = 64'h41; ALUCC = 4'b1000;
        #1 chk("sra", ALUResult, 64'hC000_0000_0000_0000);
        ALUCC = 4'b0101;
        #1 chk("srl", ALUResult, 64'h4000_0000_0000_0000);
        SrcA = {$urandom, $urandom}; SrcB = {$urandom, $urandom}; ALUCC = 4'b1111;
        #1 chk("undef_cc", ALUResult, 64'd0);

        // Store then load through ALU address 0x208 (word 8).
        SrcA = 64'h208; SrcB = 64'd0; ALUCC = ALU_ADD; mb.addr = 9'd8;
        mb.wr_en = 1'b1; WriteData = 64'hDEADBEEF;
        tick();
        mb.wr_en = 1'b0; mb.rd_en = 1'b1;
        #1 chk("ld_8", mb.rdata, 64'hDEADBEEF);
        mb.rd_en = 1'b0;
        #1 chk("ld_8_gated", mb.rdata, 64'd0);

        set_addr(9'd3); mb.wr_en = 1'b1; WriteData = 64'h1234;
        tick();
        mb.rd_en = 1'b1; mb.wr_en = 1'b0;
        #1 chk("ld_3", mb.rdata, 64'h1234);
        reset = 1'b1; mb.wr_en = 1'b1; WriteData = 64'h5555;
        tick();
        reset = 1'b0; mb.wr_en = 1'b0;
        #1 chk("ld_3_after_rst", mb.rdata, 64'd0);
        set_addr(9'd8);
        #1 chk("ld_8_after_rst", mb.rdata, 64'd0);

        // Random combinational sweep.
        for (int i = 0; i < 200; i++) begin
            pc_a = 9'($urandom); pc_b = 9'($urandom);
            SrcA = {$urandom, $urandom}; SrcB = {$urandom, $urandom};
            if (i % 4 == 0) SrcA[63] = 1'b1;
            if (i % 5 == 0) SrcB = SrcA;
            cc = 4'($urandom);
            ALUCC = cc;
            #1;
            chk("pc_rand", {55'd0, pc_sum}, 64'((int'(pc_a) + int'(pc_b)) % 512));
            chk("alu_rand", ALUResult, ref_alu(SrcA, SrcB, cc));
            @(negedge clk);
        end

        // Random memory traffic on a small address window, with occasional resets.
        for (int i = 0; i < 300; i++) begin
            a = 9'($urandom_range(0, 15));
            set_addr(a);
            mb.rd_en = 1'($urandom);
            mb.wr_en = ($urandom % 3) == 0;
            WriteData = {$urandom, $urandom};
            rst = ($urandom % 25) == 0;
            reset = rst;
            #1;
            chk("addr_low", {55'd0, ALUResult[8:0]}, {55'd0, a});
            chk("rd_pre", mb.rdata, mb.rd_en ? mm[a] : 64'd0);
            tick();
            #1 chk("rd_post", mb.rdata, mb.rd_en ? mm[a] : 64'd0);
            reset = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
